// File: rtl/dec8_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// dec8_rr_arbiter_if
// Bundles the request side and the decoder-facing grant side of the
// eight-way round-robin arbiter.
//
// Signals:
//   req     [7:0]  request vector, bit i = requester i (level, held while wanted)
//   mask    [7:0]  bit i high makes requester i ineligible
//   sel     [2:0]  index of current owner, decoder select
//   en             grant active, decoder enable
//   gnt     [7:0]  one-hot grant, 8'h00 when en is low
//   preempt        one-cycle pulse when a grant ended because the hold limit ran out
//
// Modports:
//   master  the arbiter itself (drives the decoder select/enable/grant)
//   slave   the requesters and decoder stage (drive req/mask, observe grants)
// -----------------------------------------------------------------------------
interface dec8_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       en;
    logic [7:0] gnt;
    logic       preempt;

    modport master (
        input  req,
        input  mask,
        output sel,
        output en,
        output gnt,
        output preempt
    );

    modport slave (
        output req,
        output mask,
        input  sel,
        input  en,
        input  gnt,
        input  preempt
    );
endinterface

// File: rtl/dec8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dec8_rr_arbiter
// Round-robin arbiter sharing one 8-way one-hot decoded resource among eight
// requesters. A grant is held until the owner drops its request, becomes
// masked, or has held the resource for MAX_HOLD cycles. Every release is
// followed by at least one idle cycle before the next grant.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per ownership (1..255)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dec8_rr_arbiter_if.master: req/mask in, sel/en/gnt/preempt out
// -----------------------------------------------------------------------------
module dec8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dec8_rr_arbiter_if.master        bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q,   state_d;
    logic [2:0] sel_q,     sel_d;
    logic       en_q,      en_d;
    logic [7:0] gnt_q,     gnt_d;
    logic       preempt_q, preempt_d;
    logic [7:0] holdCnt_q, holdCnt_d;
    logic [2:0] last_q,    last_d;

    logic [7:0] elig;
    logic       found;
    logic [2:0] winner;
    logic       relReq;
    logic       relMask;
    logic       relCnt;

    assign elig = bus.req & ~bus.mask;

    // Release causes for the current owner. Only the owner's own request and
    // mask bits matter; other requesters never disturb an active grant.
    assign relReq  = ~bus.req[sel_q];
    assign relMask = bus.mask[sel_q];
    assign relCnt  = (holdCnt_q == 8'(MAX_HOLD));

    // Rotating priority search: start just after the last owner and wrap
    // 7->0, so the last owner is examined last (offset 8 wraps back to it).
    always_comb begin
        logic [2:0] idx;
        found  = 1'b0;
        winner = 3'd0;
        idx    = 3'd0;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = last_q + 3'(i);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Next-state and output logic. IDLE arbitrates; GRANT counts hold cycles
    // and drops back to IDLE on any release cause, which guarantees the
    // one-cycle gap between owners. preempt only flags a purely
    // counter-driven release.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        en_d      = en_q;
        gnt_d     = gnt_q;
        preempt_d = 1'b0;
        holdCnt_d = holdCnt_q;
        last_d    = last_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = GRANT;
                    sel_d     = winner;
                    en_d      = 1'b1;
                    gnt_d     = 8'(1) << winner;
                    holdCnt_d = 8'd1;
                end
            end
            GRANT: begin
                if (relReq || relMask || relCnt) begin
                    state_d   = IDLE;
                    en_d      = 1'b0;
                    gnt_d     = 8'h00;
                    last_d    = sel_q;
                    holdCnt_d = 8'd0;
                    preempt_d = relCnt && !relReq && !relMask;
                end else begin
                    holdCnt_d = holdCnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                gnt_d   = 8'h00;
            end
        endcase
    end

    // State and output registers. last resets to 7 so the very first
    // arbitration after reset favours requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 3'd0;
            en_q      <= 1'b0;
            gnt_q     <= 8'h00;
            preempt_q <= 1'b0;
            holdCnt_q <= 8'd0;
            last_q    <= 3'd7;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            gnt_q     <= gnt_d;
            preempt_q <= preempt_d;
            holdCnt_q <= holdCnt_d;
            last_q    <= last_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.en      = en_q;
    assign bus.gnt     = gnt_q;
    assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_dec8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dec8_rr_arbiter
// Directed bench for dec8_rr_arbiter. One instance uses MAX_HOLD=4 for the
// reset, release, rotation, mask and wrap scenarios; a second instance uses
// MAX_HOLD=1 for the alternating-grant scenario.
// -----------------------------------------------------------------------------
module tb_dec8_rr_arbiter;

    logic clk;
    logic rst_n;

    int checkCount;
    int errCount;

    dec8_rr_arbiter_if if4 ();
    dec8_rr_arbiter_if if1 ();

    dec8_rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    dec8_rr_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives the request and mask vectors of the MAX_HOLD=4 instance.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] m);
        if4.req  = r;
        if4.mask = m;
    endtask

    // Advances to just after the next rising edge, where outputs are stable.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        checkCount = 0;
        errCount   = 0;
        rst_n      = 1'b0;
        if4.req    = 8'h00;
        if4.mask   = 8'h00;
        if1.req    = 8'h00;
        if1.mask   = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_sel",     if4.sel,     3'd0);
        checkOutput("rst_en",      if4.en,      1'b0);
        checkOutput("rst_gnt",     if4.gnt,     8'h00);
        checkOutput("rst_preempt", if4.preempt, 1'b0);
        checkOutput("rst_gnt1",    if1.gnt,     8'h00);
        rst_n = 1'b1;

        // Reset in the middle of a grant to requester 5.
        applyStimulus(8'h20, 8'h00);
        stepClock();
        checkOutput("mid_sel5", if4.sel, 3'd5);
        checkOutput("mid_gnt5", if4.gnt, 8'h20);
        checkOutput("mid_en5",  if4.en,  1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_en",      if4.en,      1'b0);
        checkOutput("async_gnt",     if4.gnt,     8'h00);
        checkOutput("async_preempt", if4.preempt, 1'b0);
        checkOutput("async_sel",     if4.sel,     3'd0);
        #1 rst_n = 1'b1;
        applyStimulus(8'h01, 8'h00);
        stepClock();
        checkOutput("post_rst_gnt0", if4.gnt, 8'h01);
        applyStimulus(8'h00, 8'h00);
        stepClock();
        checkOutput("post_rst_rel", if4.gnt, 8'h00);

        // Voluntary release by requester 3 after two grant cycles.
        applyStimulus(8'h08, 8'h00);
        stepClock();
        checkOutput("vol_gnt_c0", if4.gnt, 8'h08);
        stepClock();
        checkOutput("vol_gnt_c1", if4.gnt, 8'h08);
        applyStimulus(8'h00, 8'h00);
        stepClock();
        checkOutput("vol_rel_gnt",     if4.gnt,     8'h00);
        checkOutput("vol_rel_preempt", if4.preempt, 1'b0);

        // Rotation with everyone requesting, starting from a fresh reset so
        // requester 0 goes first. The final grant sees req drop together with
        // counter expiry, so no preempt pulse is expected there.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        applyStimulus(8'hFF, 8'h00);
        for (int o = 0; o < 9; o++) begin
            for (int c = 0; c < 4; c++) begin
                stepClock();
                checkOutput($sformatf("rot_gnt_o%0d_c%0d", o, c), if4.gnt, 32'h1 << (o % 8));
                checkOutput($sformatf("rot_sel_o%0d_c%0d", o, c), if4.sel, o % 8);
                if (c == 0)
                    checkOutput($sformatf("rot_pre_on_o%0d", o), if4.preempt, 1'b0);
            end
            if (o == 8)
                applyStimulus(8'h00, 8'h00);
            stepClock();
            checkOutput($sformatf("rot_gap_gnt_o%0d", o), if4.gnt, 8'h00);
            checkOutput($sformatf("rot_gap_en_o%0d", o),  if4.en,  1'b0);
            checkOutput($sformatf("rot_gap_pre_o%0d", o), if4.preempt, (o < 8) ? 1'b1 : 1'b0);
        end

        // Mask: requester 7 masked, 4 wins; masking 4 mid-grant releases it,
        // and 7 takes over once its mask clears.
        applyStimulus(8'h90, 8'h80);
        stepClock();
        checkOutput("mask_gnt4_c0", if4.gnt, 8'h10);
        stepClock();
        checkOutput("mask_gnt4_c1", if4.gnt, 8'h10);
        applyStimulus(8'h90, 8'h90);
        stepClock();
        checkOutput("mask_rel_gnt",     if4.gnt,     8'h00);
        checkOutput("mask_rel_preempt", if4.preempt, 1'b0);
        stepClock();
        checkOutput("mask_all_idle", if4.gnt, 8'h00);
        applyStimulus(8'h90, 8'h00);
        stepClock();
        checkOutput("mask_gnt7", if4.gnt, 8'h80);
        checkOutput("mask_sel7", if4.sel, 3'd7);
        applyStimulus(8'h00, 8'h00);
        stepClock();
        checkOutput("mask_end", if4.gnt, 8'h00);

        // Wrap: make 6 the last owner, then 0 must beat 6.
        applyStimulus(8'h40, 8'h00);
        stepClock();
        checkOutput("wrap_gnt6_first", if4.gnt, 8'h40);
        applyStimulus(8'h00, 8'h00);
        stepClock();
        checkOutput("wrap_rel6", if4.gnt, 8'h00);
        applyStimulus(8'h41, 8'h00);
        stepClock();
        checkOutput("wrap_gnt0", if4.gnt, 8'h01);
        applyStimulus(8'h40, 8'h00);
        stepClock();
        checkOutput("wrap_gap", if4.gnt, 8'h00);
        stepClock();
        checkOutput("wrap_gnt6", if4.gnt, 8'h40);
        checkOutput("wrap_sel6", if4.sel, 3'd6);
        applyStimulus(8'h00, 8'h00);
        stepClock();
        checkOutput("wrap_end", if4.gnt, 8'h00);

        // MAX_HOLD=1: grant toggles every cycle, preempt in each off cycle.
        if1.req = 8'h01;
        for (int k = 0; k < 3; k++) begin
            stepClock();
            checkOutput($sformatf("mh1_on_gnt_%0d", k), if1.gnt,     8'h01);
            checkOutput($sformatf("mh1_on_pre_%0d", k), if1.preempt, 1'b0);
            stepClock();
            checkOutput($sformatf("mh1_off_gnt_%0d", k), if1.gnt,     8'h00);
            checkOutput($sformatf("mh1_off_pre_%0d", k), if1.preempt, 1'b1);
        end
        if1.req = 8'h00;
        stepClock();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
